// File: rtl/dac_ramp_serializer.sv
// Sawtooth/triangle ramp generator that serialises each code into 24-bit SPI
// frames (6 pad bits, 2 power-down bits, 16 data bits) for an external serial DAC.
module dac_ramp_serializer #(
    parameter int FRAME_BITS = 24,
    parameter int DATA_W     = 16,
    parameter int GAP_CYCLES = 2,
    parameter int HOLD_W     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic [DATA_W-1:0] start_code,
    input  logic [DATA_W-1:0] stop_code,
    input  logic [DATA_W-1:0] step,
    input  logic [HOLD_W-1:0] hold_frames,
    input  logic              mode,
    input  logic [1:0]        pd_bits,
    output logic              Din,
    output logic              SYNC_bar,
    output logic [DATA_W-1:0] code_out,
    output logic              frame_done,
    output logic              busy
);

    localparam int PAD_W = FRAME_BITS - DATA_W - 2;
    localparam int BIT_W = $clog2(FRAME_BITS);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t                  state_r;
    logic [FRAME_BITS-1:0]   shreg_r;
    logic [DATA_W-1:0]       code_r;
    logic                    dir_r;
    logic                    fresh_r;
    logic [BIT_W-1:0]        bit_cnt_r;
    logic [GAP_W-1:0]        gap_cnt_r;
    logic [HOLD_W-1:0]       hold_cnt_r;
    logic [DATA_W-1:0]       start_r;
    logic [DATA_W-1:0]       stop_r;
    logic [DATA_W-1:0]       step_r;
    logic [HOLD_W-1:0]       hold_r;
    logic                    mode_r;

    logic [DATA_W-1:0]       cur_code_s;
    logic [FRAME_BITS-1:0]   word_s;
    logic [DATA_W:0]         sum_s;
    logic [DATA_W:0]         floor_s;
    logic [DATA_W-1:0]       nxt_code_s;
    logic                    nxt_dir_s;

    // fresh_r marks "ramp restarts at start_code"; it stands in for an async load of start_code
    assign cur_code_s = fresh_r ? start_code : code_r;
    assign code_out   = cur_code_s;
    assign word_s     = {{PAD_W{1'b0}}, pd_bits, cur_code_s};

    // Next ramp code from the configuration latched at LOAD; DATA_W+1-bit sums never wrap
    always_comb begin
        sum_s      = {1'b0, code_r} + {1'b0, step_r};
        floor_s    = {1'b0, start_r} + {1'b0, step_r};
        nxt_code_s = code_r;
        nxt_dir_s  = dir_r;
        if ((step_r == {DATA_W{1'b0}}) || (start_r >= stop_r)) begin
            nxt_code_s = start_r;
            nxt_dir_s  = 1'b0;
        end else if (!mode_r) begin
            if (sum_s > {1'b0, stop_r}) begin
                nxt_code_s = start_r;
            end else begin
                nxt_code_s = sum_s[DATA_W-1:0];
            end
        end else if (!dir_r) begin
            if (sum_s >= {1'b0, stop_r}) begin
                nxt_code_s = stop_r;
                nxt_dir_s  = 1'b1;
            end else begin
                nxt_code_s = sum_s[DATA_W-1:0];
            end
        end else begin
            if ({1'b0, code_r} < floor_s) begin
                nxt_code_s = start_r;
                nxt_dir_s  = 1'b0;
            end else begin
                nxt_code_s = code_r - step_r;
            end
        end
    end

    // Frame sequencer: IDLE -> LOAD -> SHIFT -> GAP, with all pin outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            SYNC_bar   <= 1'b1;
            Din        <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            shreg_r    <= {FRAME_BITS{1'b0}};
            code_r     <= {DATA_W{1'b0}};
            dir_r      <= 1'b0;
            fresh_r    <= 1'b1;
            bit_cnt_r  <= {BIT_W{1'b0}};
            gap_cnt_r  <= {GAP_W{1'b0}};
            hold_cnt_r <= {HOLD_W{1'b0}};
            start_r    <= {DATA_W{1'b0}};
            stop_r     <= {DATA_W{1'b0}};
            step_r     <= {DATA_W{1'b0}};
            hold_r     <= {HOLD_W{1'b0}};
            mode_r     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    SYNC_bar <= 1'b1;
                    Din      <= 1'b0;
                    if (clk_en) begin
                        state_r <= ST_LOAD;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    start_r   <= start_code;
                    stop_r    <= stop_code;
                    step_r    <= step;
                    hold_r    <= hold_frames;
                    mode_r    <= mode;
                    code_r    <= cur_code_s;
                    fresh_r   <= 1'b0;
                    shreg_r   <= word_s << 1;
                    Din       <= word_s[FRAME_BITS-1];
                    SYNC_bar  <= 1'b0;
                    bit_cnt_r <= {BIT_W{1'b0}};
                    state_r   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bit_cnt_r == LAST_BIT) begin
                        SYNC_bar   <= 1'b1;
                        Din        <= 1'b0;
                        frame_done <= 1'b1;
                        gap_cnt_r  <= {GAP_W{1'b0}};
                        state_r    <= ST_GAP;
                    end else begin
                        Din       <= shreg_r[FRAME_BITS-1];
                        shreg_r   <= shreg_r << 1;
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == LAST_GAP) begin
                        if (hold_cnt_r == hold_r) begin
                            code_r     <= nxt_code_s;
                            dir_r      <= nxt_dir_s;
                            hold_cnt_r <= {HOLD_W{1'b0}};
                        end else begin
                            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                        end
                        if (clk_en) begin
                            state_r <= ST_LOAD;
                        end else begin
                            // disabled: the next enable restarts the ramp from start_code
                            state_r    <= ST_IDLE;
                            busy       <= 1'b0;
                            fresh_r    <= 1'b1;
                            dir_r      <= 1'b0;
                            hold_cnt_r <= {HOLD_W{1'b0}};
                        end
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    SYNC_bar <= 1'b1;
                    Din      <= 1'b0;
                    busy     <= 1'b0;
                    fresh_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_ramp_serializer.sv
// Scoreboard bench: stimulus pushes expected frames from an arithmetic ramp model,
// a monitor reassembles SPI frames from the pins and compares.
module tb_dac_ramp_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en = 1'b0;
    logic [15:0] start_code = 16'h0000;
    logic [15:0] stop_code = 16'h0000;
    logic [15:0] step = 16'h0000;
    logic [9:0]  hold_frames = 10'd0;
    logic        mode = 1'b0;
    logic [1:0]  pd_bits = 2'b00;
    logic        Din;
    logic        SYNC_bar;
    logic [15:0] code_out;
    logic        frame_done;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [23:0] exp_q[$];

    dac_ramp_serializer dut (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .start_code(start_code), .stop_code(stop_code), .step(step),
        .hold_frames(hold_frames), .mode(mode), .pd_bits(pd_bits),
        .Din(Din), .SYNC_bar(SYNC_bar), .code_out(code_out),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    bit          prev_sync = 1'b1;
    bit          in_frame = 1'b0;
    bit          run_ok = 1'b0;
    bit          code_ok = 1'b1;
    int          nbits = 0;
    int          period = 0;
    logic [23:0] word = 24'h0;
    logic [15:0] first_code = 16'h0;
    logic [23:0] exp_w;

    always @(negedge clk) begin
        if (reset) begin
            in_frame  = 1'b0;
            run_ok    = 1'b0;
            prev_sync = 1'b1;
        end else begin
            period++;
            if (!busy) run_ok = 1'b0;
            if (!SYNC_bar) begin
                if (prev_sync) begin
                    if (run_ok) check("frame_period", period, 27);
                    period     = 0;
                    run_ok     = 1'b1;
                    in_frame   = 1'b1;
                    nbits      = 0;
                    word       = 24'h0;
                    code_ok    = 1'b1;
                    first_code = code_out;
                end
                if (in_frame) begin
                    word = {word[22:0], Din};
                    nbits++;
                    if (code_out != first_code) code_ok = 1'b0;
                end
            end else if (in_frame) begin
                in_frame = 1'b0;
                check("frame_len", nbits, 24);
                check("frame_done_pulse", int'(frame_done), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got 0x%06h expected no frame", word);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("frame_bits", int'(word), int'(exp_w));
                    check("code_out", int'(first_code), int'(exp_w[15:0]));
                    check("code_stable", int'(code_ok), 1);
                end
            end else if (frame_done) begin
                check("spurious_frame_done", int'(frame_done), 0);
            end
            prev_sync = SYNC_bar;
        end
    end

    // ---------------- reference model ----------------
    task automatic model_push(input int k);
        int s, e, st, h, code, rep;
        bit down;
        logic [23:0] w;
        s = int'(start_code); e = int'(stop_code); st = int'(step); h = int'(hold_frames);
        code = s; rep = 0; down = 1'b0;
        for (int i = 0; i < k; i++) begin
            w = {6'b000000, pd_bits, 16'(code)};
            exp_q.push_back(w);
            if (rep < h) begin
                rep++;
            end else begin
                rep = 0;
                if (st == 0 || s >= e) begin
                    code = s;
                end else if (!mode) begin
                    code = (code + st > e) ? s : code + st;
                end else if (!down) begin
                    if (code + st >= e) begin code = e; down = 1'b1; end
                    else code = code + st;
                end else begin
                    if (code < s + st) begin code = s; down = 1'b0; end
                    else code = code - st;
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string what);
        int n = 0;
        @(negedge clk);
        while (!frame_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!frame_done) begin
            checks++; errors++;
            $display("FAIL timeout_%s: got no frame_done expected pulse within 200 cycles", what);
        end
    endtask

    task automatic wait_sync_low();
        int n = 0;
        while (SYNC_bar && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (SYNC_bar) begin
            checks++; errors++;
            $display("FAIL timeout_sync: got SYNC_bar=1 expected frame start within 100 cycles");
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", int'(busy), 0);
        tick(3);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic run(input int k);
        model_push(k);
        clk_en = 1'b1;
        for (int i = 0; i < k; i++) wait_done("run");
        clk_en = 1'b0;
        wait_idle();
    endtask

    task automatic cfg(input logic [15:0] s, input logic [15:0] e, input logic [15:0] st,
                       input logic [9:0] h, input logic m, input logic [1:0] pd);
        start_code = s; stop_code = e; step = st; hold_frames = h; mode = m; pd_bits = pd;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt, lowcnt;
        cfg(16'h1000, 16'h2000, 16'h0100, 10'd0, 1'b0, 2'b00);
        clk_en = 1'b1;
        tick(3);
        check("rst_sync_bar", int'(SYNC_bar), 1);
        check("rst_din", int'(Din), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_code_out", int'(code_out), 16'h1000);

        // first frame straight out of reset, with LOAD-to-frame_done latency
        model_push(1);
        reset = 1'b0;
        cnt = 0;
        while (!busy && cnt < 20) begin tick(1); cnt++; end
        cnt = 0;
        while (!frame_done && cnt < 100) begin tick(1); cnt++; end
        check("first_frame_done_clock", cnt, 25);
        clk_en = 1'b0;
        wait_idle();

        cfg(16'h0000, 16'h0030, 16'h0010, 10'd0, 1'b0, 2'b00); run(6);   // sawtooth
        cfg(16'h0010, 16'h0035, 16'h0010, 10'd0, 1'b1, 2'b01); run(9);   // triangle clamps
        cfg(16'h0000, 16'h0020, 16'h0010, 10'd2, 1'b0, 2'b10); run(9);   // hold
        cfg(16'h0000, 16'hFFFF, 16'h8000, 10'd0, 1'b0, 2'b11); run(4);   // no 16-bit wrap
        cfg(16'h0050, 16'h0050, 16'h0010, 10'd0, 1'b1, 2'b00); run(3);   // start>=stop
        cfg(16'h0020, 16'h0080, 16'h0000, 10'd0, 1'b0, 2'b00); run(3);   // step=0

        // clk_en dropped at bit 5: frame completes, then no more frames
        cfg(16'h0100, 16'h0400, 16'h0100, 10'd0, 1'b0, 2'b00);
        model_push(1);
        clk_en = 1'b1;
        wait_sync_low();
        tick(5);
        clk_en = 1'b0;
        wait_done("disable");
        lowcnt = 0;
        for (int i = 0; i < 40; i++) begin tick(1); if (!SYNC_bar) lowcnt++; end
        check("idle_after_disable", lowcnt, 0);
        check("busy_after_disable", int'(busy), 0);
        check("queue_after_disable", exp_q.size(), 0);
        run(3);   // re-enable restarts at start_code

        // asynchronous reset at bit 10
        cfg(16'h0A50, 16'h0B00, 16'h0010, 10'd0, 1'b0, 2'b00);
        clk_en = 1'b1;
        wait_sync_low();
        tick(10);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_sync_bar", int'(SYNC_bar), 1);
        check("async_rst_din", int'(Din), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_frame_done", int'(frame_done), 0);
        check("async_rst_code_out", int'(code_out), 16'h0A50);
        clk_en = 1'b0;
        tick(3);
        reset = 1'b0;
        lowcnt = 0;
        for (int i = 0; i < 30; i++) begin tick(1); if (!SYNC_bar) lowcnt++; end
        check("idle_after_reset", lowcnt, 0);

        // randomized configurations
        for (int r = 0; r < 16; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                cfg(16'($urandom), 16'($urandom), 16'($urandom), 10'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            end else begin
                cfg(16'($urandom_range(0, 200)), 16'($urandom_range(0, 400)),
                    16'($urandom_range(0, 60)), 10'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            end
            run($urandom_range(3, 10));
        end

        check("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dac_ramp_serializer.md
Name: dac_ramp_serializer

Overview:
Generates a programmable sawtooth or triangle voltage ramp for the electrode/bias DAC. It serialises each code into 24-bit SPI frames and drives the SYNC_bar/DIN pins of the external 16-bit serial DAC (6 don't-care bits, 2 power-down bits, 16 data bits), clocked by the same clock the top level forwards to DAC_CLK. It sits directly upstream of the DAC pins, alongside the DC-bias DAC driver, and is configured by the host over okWireIn endpoints.

Parameters:
FRAME_BITS, 24, SPI frame length in clocks with SYNC_bar low
DATA_W, 16, DAC code width
GAP_CYCLES, 2, clocks SYNC_bar stays high between frames (minimum 1)
HOLD_W, 10, width of the per-code frame-repeat counter

Ports:
clk  in  1  DAC serial clock; the DAC samples DIN on the falling edge, so the block updates DIN on the rising edge
reset  in  1  asynchronous, active-high
clk_en  in  1  run enable (host wire)
start_code  in  DATA_W  ramp lower bound
stop_code  in  DATA_W  ramp upper bound
step  in  DATA_W  code increment per advance
hold_frames  in  HOLD_W  extra frames each code is repeated (0 = one frame per code)
mode  in  1  0 = sawtooth, 1 = triangle
pd_bits  in  2  DAC power-down field (00 = normal)
Din  out  1  serial data, MSB first
SYNC_bar  out  1  frame sync, active low
code_out  out  DATA_W  code currently being shifted
frame_done  out  1  one-cycle pulse on the clock after the last bit of each frame
busy  out  1  high from LOAD through GAP

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, SYNC_bar=1, Din=0, code_out=start_code, dir=up, bit counter=0, hold counter=0, frame_done=0, busy=0. Reset asserted mid-frame raises SYNC_bar immediately; the DAC discards the truncated frame.
- FSM states: IDLE -> LOAD -> SHIFT -> GAP -> LOAD or IDLE.
  - IDLE: SYNC_bar=1. Go to LOAD when clk_en=1. On entry from a disabled period, code_out=start_code and dir=up.
  - LOAD (1 cycle): latch shift register = {6'b0, pd_bits, code_out}. Config inputs are sampled only here.
  - SHIFT: SYNC_bar=0 for exactly FRAME_BITS cycles. Din = shreg[23] on the first SHIFT cycle, then shift left each cycle.
  - GAP: SYNC_bar=1, Din=0 for GAP_CYCLES cycles. frame_done pulses in the first GAP cycle.
- Frame period is 1 + FRAME_BITS + GAP_CYCLES clocks (27 with the defaults).
- Code advance happens at the end of GAP, only when hold counter == hold_frames. The hold counter then clears; otherwise it increments.
  - All arithmetic uses DATA_W+1 bits, so the sum cannot wrap.
  - Sawtooth: if code+step > stop_code, then code=start_code; else code=code+step.
  - Triangle, up: if code+step >= stop_code, then code=stop_code and dir=down; else code+=step.
  - Triangle, down: if code < start_code+step, then code=start_code and dir=up; else code-=step.
  - step=0 or start_code>=stop_code: code holds at start_code. This is not an error.
- clk_en deasserted mid-frame: the current frame and its GAP complete, then the FSM goes to IDLE. It is never truncated.
- clk_en reasserted during GAP: the FSM continues without returning to IDLE.
- code_out changes only at the GAP->LOAD boundary, and is stable throughout SHIFT.

Test Plan:
- Reset release with clk_en=1, start=0x1000, pd=00 -> first frame: SYNC_bar low for exactly 24 clocks, serial bits = 0x001000 MSB first, frame_done pulse at clock 25 after LOAD.
- Sawtooth: start=0, stop=0x0030, step=0x10, hold=0 -> code sequence 0x00,0x10,0x20,0x30,0x00,... with a frame period of 27 clocks.
- Triangle: start=0x10, stop=0x35, step=0x10 -> 0x10,0x20,0x30,0x35,0x25,0x15,0x10,0x20 (clamping at both ends).
- hold_frames=2 -> each code appears in exactly 3 consecutive frames. Boundary check: stop=0xFFFF, step=0x8000, sawtooth -> 0x0000,0x8000,0x0000 with no 16-bit wrap.
- clk_en dropped at bit 5 of a frame -> the frame still completes all 24 bits, then SYNC_bar stays high. Re-enable -> restarts at start_code.
- reset pulsed at bit 10 -> SYNC_bar goes high in the same cycle (asynchronously), and all outputs return to their reset values.
